// File: rtl/sort_pkg.sv
// Shared definitions for the sorter output serializer.
//   NUM_ELEMS   elements per sorted frame
//   IDX_W       width of the element index within a frame
//   ser_state_e output FSM states of the serializer
package sort_pkg;

    localparam int NUM_ELEMS = 8;
    localparam int IDX_W     = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/sort_frame_buf.sv
// Circular frame buffer: FRAMES slots of NUM_ELEMS x BITWIDTH elements.
//   clk, resetn  clock, asynchronous active-low reset (pointers/count only)
//   push         write wdata into slot wr_ptr, advance wr_ptr
//   pop          release slot rd_ptr, advance rd_ptr
//   wdata        packed frame, element i = wdata[i*BITWIDTH +: BITWIDTH]
//   rd_idx       element index to read from slot rd_ptr
//   rdata        element rd_idx of slot rd_ptr (mux of stored registers)
//   count        frames held; full / empty status flags
module sort_frame_buf
    import sort_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int FRAMES   = 2,
    localparam int PTR_W   = $clog2(FRAMES),
    localparam int CNT_W   = $clog2(FRAMES) + 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          push,
    input  logic                          pop,
    input  logic [NUM_ELEMS*BITWIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]              rd_idx,
    output logic [BITWIDTH-1:0]           rdata,
    output logic [CNT_W-1:0]              count,
    output logic                          full,
    output logic                          empty
);

    logic [BITWIDTH-1:0] mem_q [FRAMES][NUM_ELEMS];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // Pointers wrap naturally because FRAMES is a power of two.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Frame storage carries no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
                mem_q[wr_ptr_q][i] <= wdata[i*BITWIDTH +: BITWIDTH];
            end
        end
    end

    assign rdata = mem_q[rd_ptr_q][rd_idx];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(FRAMES));
    assign empty = (count_q == '0);

endmodule

// File: rtl/sort_frame_serializer.sv
// Serializes sorted 8-element frames from the one-cycle sorter into a
// valid/ready element stream, element 0 (largest) first.
//   clk, resetn  clock, asynchronous active-low reset
//   sortit       sorter strobe; the sorter result is taken one cycle later
//   frame_in     sorter dout: [8*BITWIDTH] valid, element i at [i*BITWIDTH +: BITWIDTH]
//   m_data       current element          m_valid  beat valid
//   m_ready      sink ready               m_idx    element index 0..7
//   m_last       beat with m_idx == 7     busy     buffer non-empty
//   overflow     sticky frame-drop flag   drop_cnt saturating dropped-frame count
module sort_frame_serializer
    import sort_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int FRAMES   = 2,
    parameter int DROP_W   = 8,
    localparam int CNT_W   = $clog2(FRAMES) + 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        sortit,
    input  logic [NUM_ELEMS*BITWIDTH:0] frame_in,
    output logic [BITWIDTH-1:0]         m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [IDX_W-1:0]            m_idx,
    output logic                        m_last,
    output logic                        busy,
    output logic                        overflow,
    output logic [DROP_W-1:0]           drop_cnt
);

    ser_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                sortit_q;
    logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic                overflow_q, overflow_d;

    logic                frame_stb, beat_fire, push, pop, drop;
    logic [BITWIDTH-1:0] rdata;
    logic [CNT_W-1:0]    count;
    logic                full, empty;

    sort_frame_buf #(
        .BITWIDTH (BITWIDTH),
        .FRAMES   (FRAMES)
    ) u_buf (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .wdata  (frame_in[NUM_ELEMS*BITWIDTH-1:0]),
        .rd_idx (idx_q),
        .rdata  (rdata),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    assign frame_stb = sortit_q & frame_in[NUM_ELEMS*BITWIDTH];
    assign beat_fire = m_valid & m_ready;
    assign pop       = beat_fire & (idx_q == IDX_W'(NUM_ELEMS - 1));
    // A full buffer still accepts a frame when its oldest frame leaves this cycle.
    assign push      = frame_stb & (~full | pop);
    assign drop      = frame_stb & ~push;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (push || !empty) state_d = ST_SEND;
            end
            ST_SEND: begin
                // idx wraps 7 -> 0 on the last beat of a frame.
                if (beat_fire) idx_d = idx_q + IDX_W'(1);
                if (pop && !push && count == CNT_W'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sortit_q   <= 1'b0;
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            sortit_q   <= sortit;
            state_q    <= state_d;
            idx_q      <= idx_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign m_valid  = (state_q == ST_SEND);
    assign m_data   = m_valid ? rdata : '0;
    assign m_idx    = idx_q;
    assign m_last   = m_valid & (idx_q == IDX_W'(NUM_ELEMS - 1));
    assign busy     = ~empty;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule
